nonce_report_tx: RTL and testbench

- Return path of the host link. Collects golden nonces and the job-complete event from the hash core, all in the clk_h domain.
- Queues results in a small FIFO and presents them one at a time to the USB status/nonce path, using a valid/ack handshake.
- Replaces the single-shot success/unsuccess flags. Multiple nonces per job are no longer lost, and completion is reported only after every queued nonce has been delivered.

---
 rtl/nonce_report_tx.sv | 143 ++++++++++++++
 tb/tb_nonce_report_tx.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/nonce_report_tx.sv
// Golden-nonce / job-complete return path: queues nonces in a small FIFO and
// presents them one at a time, then reports completion, over a valid/ack link.
module nonce_report_tx #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic        clk_h,
  input  logic        rst_n,
  input  logic        start_hash,
  input  logic        host_break,
  input  logic        ticket2moon,
  input  logic [31:0] nonce,
  input  logic        hash_cmplt,
  output logic        rpt_valid,
  output logic [31:0] rpt_status,
  output logic [31:0] rpt_nonce,
  input  logic        rpt_ack,
  output logic [3:0]  fifo_level
);

  typedef enum logic [1:0] {IDLE, LOAD, LOAD_DONE, WAIT_ACK} state_t;

  localparam logic [AW:0]  FULL_LVL   = (AW+1)'(DEPTH);
  localparam logic [15:0]  CODE_NONCE = 16'h2121;
  localparam logic [15:0]  CODE_DONE  = 16'hffff;

  state_t        state, state_nx;
  logic          start_q;
  logic          clr;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic [7:0]    seq;
  logic          ovf, cmplt_pend;
  logic          full, empty, push, pop, drop;

  // A start_hash rising edge or host_break flushes everything in one cycle
  assign clr   = host_break | (start_hash & ~start_q);
  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);
  // A pop in the same cycle frees a slot, so a push at full is still accepted
  assign pop   = (state == LOAD) & ~clr;
  assign push  = ticket2moon & ~clr & (~full | pop);
  assign drop  = ticket2moon & ~clr & full & ~pop;
  assign fifo_level = 4'(level);

  // Previous start_hash value for edge detection
  always_ff @(posedge clk_h or negedge rst_n) begin
    if (!rst_n) start_q <= 1'b0;
    else        start_q <= start_hash;
  end

  // FIFO storage (no reset needed; validity tracked by level)
  always_ff @(posedge clk_h) begin
    if (push) mem[wr_ptr] <= nonce;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_h or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  // Sequence number, sticky overflow and pending completion
  always_ff @(posedge clk_h or negedge rst_n) begin
    if (!rst_n) begin
      seq        <= '0;
      ovf        <= 1'b0;
      cmplt_pend <= 1'b0;
    end else if (clr) begin
      seq        <= '0;
      ovf        <= 1'b0;
      cmplt_pend <= 1'b0;
    end else begin
      if (state == LOAD || state == LOAD_DONE) seq <= seq + 8'd1;
      if (drop) ovf <= 1'b1;
      // A new hash_cmplt landing on the LOAD_DONE cycle must not be lost
      if (hash_cmplt)               cmplt_pend <= 1'b1;
      else if (state == LOAD_DONE)  cmplt_pend <= 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk_h or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic: queued nonces take priority over completion
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (!empty)          state_nx = LOAD;
        else if (cmplt_pend) state_nx = LOAD_DONE;
      end
      LOAD:      state_nx = WAIT_ACK;
      LOAD_DONE: state_nx = WAIT_ACK;
      WAIT_ACK:  if (rpt_ack) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
    if (clr) state_nx = IDLE;
  end

  // Report output registers, held stable while waiting for ack
  always_ff @(posedge clk_h or negedge rst_n) begin
    if (!rst_n) begin
      rpt_valid  <= 1'b0;
      rpt_status <= '0;
      rpt_nonce  <= '0;
    end else if (clr) begin
      rpt_valid <= 1'b0;
    end else begin
      unique case (state)
        LOAD: begin
          rpt_nonce  <= mem[rd_ptr];
          rpt_status <= {ovf, 2'b00, start_hash, CODE_NONCE, 4'(level), seq};
          rpt_valid  <= 1'b1;
        end
        LOAD_DONE: begin
          rpt_nonce  <= '1;
          rpt_status <= {ovf, 2'b00, start_hash, CODE_DONE, 4'(level), seq};
          rpt_valid  <= 1'b1;
        end
        WAIT_ACK:  if (rpt_ack) rpt_valid <= 1'b0;
        default:   ;
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_report_tx.sv
// Directed self-checking bench for nonce_report_tx.
module tb_nonce_report_tx;

  logic        clk_h = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_hash = 1'b0;
  logic        host_break = 1'b0;
  logic        ticket2moon = 1'b0;
  logic [31:0] nonce = '0;
  logic        hash_cmplt = 1'b0;
  logic        rpt_valid;
  logic [31:0] rpt_status;
  logic [31:0] rpt_nonce;
  logic        rpt_ack = 1'b0;
  logic [3:0]  fifo_level;

  int total = 0;
  int bad   = 0;

  nonce_report_tx #(.DEPTH(8), .AW(3)) dut (
    .clk_h(clk_h), .rst_n(rst_n), .start_hash(start_hash), .host_break(host_break),
    .ticket2moon(ticket2moon), .nonce(nonce), .hash_cmplt(hash_cmplt),
    .rpt_valid(rpt_valid), .rpt_status(rpt_status), .rpt_nonce(rpt_nonce),
    .rpt_ack(rpt_ack), .fifo_level(fifo_level)
  );

  always #5 clk_h = ~clk_h;

  task automatic step();
    @(posedge clk_h);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic epoch();
    start_hash = 1'b0;
    step();
    start_hash = 1'b1;
    step();
  endtask

  task automatic push_one(input logic [31:0] n, input logic cmplt);
    ticket2moon = 1'b1;
    nonce       = n;
    hash_cmplt  = cmplt;
    step();
    ticket2moon = 1'b0;
    hash_cmplt  = 1'b0;
  endtask

  // Wait (bounded) for a report, check latency and contents, hold 3 cycles, ack
  task automatic get_report(input string tag, input int exp_wait,
                            input logic [31:0] es, input logic [31:0] en);
    int k;
    k = 0;
    while (!rpt_valid && k < 20) begin
      step();
      k++;
    end
    chk($sformatf("%s.wait", tag), 32'(k), 32'(exp_wait));
    chk($sformatf("%s.status", tag), rpt_status, es);
    chk($sformatf("%s.nonce", tag), rpt_nonce, en);
    repeat (3) step();
    chk($sformatf("%s.hold", tag), {rpt_valid, rpt_status[30:0]}, {1'b1, es[30:0]});
    rpt_ack = 1'b1;
    step();
    rpt_ack = 1'b0;
    chk($sformatf("%s.drop", tag), 32'(rpt_valid), 32'd0);
  endtask

  task automatic quiet(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (rpt_valid) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    // 1: reset and single nonce
    step();
    chk("rst.valid", 32'(rpt_valid), 32'd0);
    chk("rst.status", rpt_status, 32'h0);
    chk("rst.nonce", rpt_nonce, 32'h0);
    chk("rst.level", 32'(fifo_level), 32'd0);
    rst_n = 1'b1;
    step();
    start_hash = 1'b1;
    step();
    push_one(32'h12345678, 1'b0);
    chk("t1.level", 32'(fifo_level), 32'd1);
    chk("t1.valid_n", 32'(rpt_valid), 32'd0);
    get_report("t1", 2, 32'h1212_1100, 32'h12345678);

    // 2: three nonces, completion with the last one
    epoch();
    push_one(32'haaaa0001, 1'b0);
    push_one(32'hbbbb0002, 1'b0);
    push_one(32'hcccc0003, 1'b1);
    get_report("t2.a", 0, 32'h1212_1200, 32'haaaa0001);
    get_report("t2.b", 2, 32'h1212_1201, 32'hbbbb0002);
    get_report("t2.c", 2, 32'h1212_1102, 32'hcccc0003);
    get_report("t2.done", 2, 32'h1fff_f003, 32'hffffffff);
    quiet("t2.quiet", 10);

    // 3: overflow with DEPTH+2 nonces and no ack
    epoch();
    for (int i = 0; i < 10; i++) push_one(32'h3000_0000 + 32'(i), 1'b0);
    chk("t3.level", 32'(fifo_level), 32'd8);
    get_report("t3.n0", 0, 32'h1212_1200, 32'h3000_0000);
    for (int i = 1; i <= 8; i++)
      get_report($sformatf("t3.n%0d", i), 2,
                 {1'b1, 2'b00, 1'b1, 16'h2121, 4'(9 - i), 8'(i)},
                 32'h3000_0000 + 32'(i));
    quiet("t3.quiet", 6);
    epoch();
    push_one(32'h7777_0007, 1'b0);
    get_report("t3.clr", 2, 32'h1212_1100, 32'h7777_0007);

    // 4: push and pop together at full
    epoch();
    for (int i = 0; i < 9; i++) push_one(32'h4000_0000 + 32'(i), 1'b0);
    chk("t4.full", 32'(fifo_level), 32'd8);
    get_report("t4.n0", 0, 32'h1212_1200, 32'h4000_0000);
    step();
    push_one(32'h4444_9999, 1'b0);
    chk("t4.level", 32'(fifo_level), 32'd8);
    get_report("t4.n1", 0, 32'h1212_1801, 32'h4000_0001);
    for (int i = 2; i <= 8; i++)
      get_report($sformatf("t4.n%0d", i), 2,
                 {4'b0001, 16'h2121, 4'(10 - i), 8'(i)},
                 32'h4000_0000 + 32'(i));
    get_report("t4.last", 2, 32'h1212_1109, 32'h4444_9999);

    // 5: host_break while a report is waiting for ack
    epoch();
    push_one(32'h5000_0000, 1'b0);
    push_one(32'h5000_0001, 1'b0);
    push_one(32'h5000_0002, 1'b0);
    push_one(32'h5000_0003, 1'b1);
    chk("t5.valid", 32'(rpt_valid), 32'd1);
    host_break = 1'b1;
    step();
    host_break = 1'b0;
    chk("t5.drop", 32'(rpt_valid), 32'd0);
    chk("t5.level", 32'(fifo_level), 32'd0);
    quiet("t5.quiet", 10);
    push_one(32'h5555_0005, 1'b0);
    get_report("t5.after", 2, 32'h1212_1100, 32'h5555_0005);

    // 6: asynchronous reset between edges during WAIT_ACK
    push_one(32'h6000_0000, 1'b0);
    step();
    step();
    chk("t6.valid", 32'(rpt_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6.rst_valid", 32'(rpt_valid), 32'd0);
    chk("t6.rst_status", rpt_status, 32'h0);
    chk("t6.rst_nonce", rpt_nonce, 32'h0);
    chk("t6.rst_level", 32'(fifo_level), 32'd0);
    rst_n = 1'b1;
    rpt_ack = 1'b1;
    step();
    rpt_ack = 1'b0;
    chk("t6.stray_ack", 32'(rpt_valid), 32'd0);
    quiet("t6.quiet", 5);
    chk("t6.level", 32'(fifo_level), 32'd0);
    push_one(32'h6666_0006, 1'b0);
    get_report("t6.after", 2, 32'h1212_1100, 32'h6666_0006);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
